stroke_history: RTL and testbench

- Parametrised successor to the single-entry undo/redo buffer in the Tiny Canvas datapath.
- Records every painted pixel packet (x, y, colour) in a ring buffer, tagged with stroke boundaries.
- On undo or redo, replays a whole stroke as a multi-cycle valid/ready stream. Undo replays in reverse order marked erase; redo replays in forward order.
- Sits between packet_generator (save side) and the I2C/host-facing output path.

---
 rtl/stroke_history_if.sv | 42 ++++
 rtl/stroke_history.sv | 164 ++++++++++++++++
 tb/tb_stroke_history.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stroke_history_if.sv
// Save-side and playback-side signal bundle for stroke_history.
//   master: pixel source / playback consumer (drives save, undo, redo, out_ready)
//   slave : stroke_history (drives playback stream, status and counts)
interface stroke_history_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned X_W   = 8,
  parameter int unsigned Y_W   = 8,
  parameter int unsigned C_W   = 3
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             save;
  logic             stroke_begin;
  logic [X_W-1:0]   x_in;
  logic [Y_W-1:0]   y_in;
  logic [C_W-1:0]   color_in;
  logic             undo;
  logic             redo;
  logic             out_valid;
  logic             out_ready;
  logic [X_W-1:0]   x_out;
  logic [Y_W-1:0]   y_out;
  logic [C_W-1:0]   color_out;
  logic             out_erase;
  logic             busy;
  logic             can_undo;
  logic             can_redo;
  logic [PTR_W:0]   used_count;
  logic [PTR_W:0]   redo_count;

  modport master (
    output save, stroke_begin, x_in, y_in, color_in, undo, redo, out_ready,
    input  out_valid, x_out, y_out, color_out, out_erase, busy, can_undo,
           can_redo, used_count, redo_count
  );

  modport slave (
    input  save, stroke_begin, x_in, y_in, color_in, undo, redo, out_ready,
    output out_valid, x_out, y_out, color_out, out_erase, busy, can_undo,
           can_redo, used_count, redo_count
  );
endinterface

// File: rtl/stroke_history.sv
// Stroke-aware undo/redo history: ring buffer of painted pixels with stroke
// start flags; undo replays the last stroke backwards (erase), redo replays
// the next stroke forwards, both as a valid/ready stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : stroke_history_if.slave (save/undo/redo in, playback out,
//                busy/can_undo/can_redo status, used/redo counts)
module stroke_history #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned X_W   = 8,
  parameter int unsigned Y_W   = 8,
  parameter int unsigned C_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  stroke_history_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned E_W   = X_W + Y_W + C_W;

  typedef enum logic [1:0] {IDLE, UNDO, REDO} state_e;

  logic [E_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0] start_q, start_d;
  state_e           state_q, state_d;
  logic [PTR_W-1:0] base_q, base_d, head_q, head_d, top_q, top_d;
  logic [CNT_W-1:0] used_q, used_d, redo_q, redo_d;
  logic             out_valid_q, out_valid_d;
  logic [E_W-1:0]   out_data_q, out_data_d;
  logic             out_erase_q, out_erase_d;
  logic             busy_q, can_undo_q, can_redo_q;
  logic             wr_en;
  logic             accept;
  logic [PTR_W-1:0] head_inc, head_dec, head_dec2, base_inc;

  assign head_inc  = head_q + PTR_W'(1);
  assign head_dec  = head_q - PTR_W'(1);
  assign head_dec2 = head_q - PTR_W'(2);
  assign base_inc  = base_q + PTR_W'(1);
  assign accept    = out_valid_q && bus.out_ready;

  // Next-state: save/undo/redo arbitration in IDLE, one entry per accept in playback
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    base_d      = base_q;
    head_d      = head_q;
    top_d       = top_q;
    used_d      = used_q;
    redo_d      = redo_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_erase_d = out_erase_q;
    wr_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.save) begin
          wr_en           = 1'b1;
          start_d[head_q] = bus.stroke_begin || (used_q == '0);
          head_d          = head_inc;
          top_d           = head_inc;
          redo_d          = '0;
          if (used_q == CNT_W'(DEPTH)) begin
            // Full ring: oldest entry dropped, survivor must begin a stroke
            base_d            = base_inc;
            start_d[base_inc] = 1'b1;
          end else begin
            used_d = used_q + CNT_W'(1);
          end
        end else if (bus.undo && (used_q != '0)) begin
          state_d     = UNDO;
          out_valid_d = 1'b1;
          out_data_d  = mem_q[head_dec];
          out_erase_d = 1'b1;
        end else if (bus.redo && (redo_q != '0)) begin
          state_d     = REDO;
          out_valid_d = 1'b1;
          out_data_d  = mem_q[head_q];
          out_erase_d = 1'b0;
        end
      end
      UNDO: begin
        if (accept) begin
          head_d = head_dec;
          used_d = used_q - CNT_W'(1);
          redo_d = redo_q + CNT_W'(1);
          if (start_q[head_dec] || (used_q == CNT_W'(1))) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end else begin
            out_data_d = mem_q[head_dec2];
          end
        end
      end
      REDO: begin
        if (accept) begin
          head_d = head_inc;
          used_d = used_q + CNT_W'(1);
          redo_d = redo_q - CNT_W'(1);
          // top marks the end of the redoable region
          if ((head_inc == top_q) || start_q[head_inc]) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end else begin
            out_data_d = mem_q[head_inc];
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, pointers, flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      start_q     <= '0;
      base_q      <= '0;
      head_q      <= '0;
      top_q       <= '0;
      used_q      <= '0;
      redo_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_erase_q <= 1'b0;
      busy_q      <= 1'b0;
      can_undo_q  <= 1'b0;
      can_redo_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      base_q      <= base_d;
      head_q      <= head_d;
      top_q       <= top_d;
      used_q      <= used_d;
      redo_q      <= redo_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_erase_q <= out_erase_d;
      busy_q      <= (state_d != IDLE);
      can_undo_q  <= (state_d == IDLE) && (used_d != '0);
      can_redo_q  <= (state_d == IDLE) && (redo_d != '0);
    end
  end

  // Pixel storage, intentionally without reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[head_q] <= {bus.x_in, bus.y_in, bus.color_in};
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.x_out      = out_data_q[E_W-1 -: X_W];
  assign bus.y_out      = out_data_q[C_W +: Y_W];
  assign bus.color_out  = out_data_q[C_W-1:0];
  assign bus.out_erase  = out_erase_q;
  assign bus.busy       = busy_q;
  assign bus.can_undo   = can_undo_q;
  assign bus.can_redo   = can_redo_q;
  assign bus.used_count = used_q;
  assign bus.redo_count = redo_q;
endmodule

// File: tb/tb_stroke_history.sv
// Self-checking bench for stroke_history: scoreboard of expected playback
// beats, one task per scenario.
module tb_stroke_history;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       e;
  } beat_t;

  logic  clk;
  logic  rst_n;
  int    n_cmp;
  int    n_err;
  int    beats;
  beat_t sb[$];
  beat_t mon_got;
  beat_t mon_exp;

  stroke_history_if #(.DEPTH(DEPTH), .X_W(8), .Y_W(8), .C_W(3)) bus ();

  stroke_history #(.DEPTH(DEPTH), .X_W(8), .Y_W(8), .C_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every accepted beat is popped and compared
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      beats++;
      mon_got = {bus.x_out, bus.y_out, bus.color_out, bus.out_erase};
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected got x=%0d y=%0d c=%0d e=%0d", mon_got.x, mon_got.y, mon_got.c, mon_got.e);
      end else begin
        mon_exp = sb.pop_front();
        if (mon_got !== mon_exp) begin
          n_err++;
          $display("FAIL beat got x=%0d y=%0d c=%0d e=%0d want x=%0d y=%0d c=%0d e=%0d",
                   mon_got.x, mon_got.y, mon_got.c, mon_got.e, mon_exp.x, mon_exp.y, mon_exp.c, mon_exp.e);
        end
      end
    end
  end

  task automatic drive(input logic sv, input logic beg, input logic [7:0] x, input logic [7:0] y,
                       input logic [2:0] c, input logic un, input logic re);
    @(posedge clk); #1;
    bus.save = sv; bus.stroke_begin = beg; bus.x_in = x; bus.y_in = y; bus.color_in = c;
    bus.undo = un; bus.redo = re;
    @(posedge clk); #1;
    bus.save = 1'b0; bus.undo = 1'b0; bus.redo = 1'b0; bus.stroke_begin = 1'b0;
  endtask

  task automatic push(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c, input logic e);
    beat_t b;
    b = {x, y, c, e};
    sb.push_back(b);
  endtask

  task automatic wait_idle(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!bus.busy && !bus.out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.out_valid, bus.busy, bus.can_undo, bus.can_redo, bus.out_erase} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 00000", {bus.out_valid, bus.busy, bus.can_undo, bus.can_redo, bus.out_erase});
    end
    n_cmp++;
    if ({bus.used_count, bus.redo_count, bus.x_out, bus.y_out, bus.color_out} !== '0) begin
      n_err++; $display("FAIL reset_counts used=%0d redo=%0d x=%0d", bus.used_count, bus.redo_count, bus.x_out);
    end
  endtask

  task automatic test_undo_basic();
    logic ok;
    drive(1, 1, 1, 1, 1, 0, 0);
    drive(1, 0, 2, 1, 1, 0, 0);
    drive(1, 0, 3, 1, 1, 0, 0);
    n_cmp++;
    if (bus.used_count !== 5'd3 || bus.can_undo !== 1'b1) begin
      n_err++; $display("FAIL undo_basic_pre used=%0d can_undo=%b want 3 1", bus.used_count, bus.can_undo);
    end
    push(3, 1, 1, 1); push(2, 1, 1, 1); push(1, 1, 1, 1);
    drive(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin
        n_err++; $display("FAIL undo_basic_valid beat %0d got %b want 1", i, bus.out_valid);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.used_count !== 5'd0 || bus.redo_count !== 5'd3 || bus.can_redo !== 1'b1) begin
      n_err++; $display("FAIL undo_basic_post valid=%b used=%0d redo=%0d can_redo=%b want 0 0 3 1",
                        bus.out_valid, bus.used_count, bus.redo_count, bus.can_redo);
    end
    wait_idle(10, ok);
    n_cmp++;
    if (!ok || sb.size() != 0) begin
      n_err++; $display("FAIL undo_basic_drain idle=%b left=%0d want 1 0", ok, sb.size());
    end
  endtask

  task automatic test_redo_basic();
    logic ok;
    push(1, 1, 1, 0); push(2, 1, 1, 0); push(3, 1, 1, 0);
    beats = 0;
    drive(0, 0, 0, 0, 0, 0, 1);
    wait_idle(20, ok);
    n_cmp++;
    if (!ok || sb.size() != 0 || beats != 3) begin
      n_err++; $display("FAIL redo_basic_drain idle=%b left=%0d beats=%0d want 1 0 3", ok, sb.size(), beats);
    end
    n_cmp++;
    if (bus.used_count !== 5'd3 || bus.redo_count !== 5'd0 || bus.can_redo !== 1'b0 || bus.can_undo !== 1'b1) begin
      n_err++; $display("FAIL redo_basic_post used=%0d redo=%0d can_redo=%b can_undo=%b want 3 0 0 1",
                        bus.used_count, bus.redo_count, bus.can_redo, bus.can_undo);
    end
  endtask

  task automatic test_strokes();
    logic ok;
    apply_reset();
    drive(1, 1, 5, 5, 2, 0, 0);
    drive(1, 0, 6, 5, 2, 0, 0);
    drive(1, 1, 9, 9, 3, 0, 0);
    push(9, 9, 3, 1);
    beats = 0;
    drive(0, 0, 0, 0, 0, 1, 0);
    wait_idle(20, ok);
    n_cmp++;
    if (!ok || sb.size() != 0 || beats != 1 || bus.used_count !== 5'd2 || bus.redo_count !== 5'd1 || bus.can_redo !== 1'b1) begin
      n_err++; $display("FAIL strokes_undo idle=%b beats=%0d used=%0d redo=%0d can_redo=%b want 1 1 2 1 1",
                        ok, beats, bus.used_count, bus.redo_count, bus.can_redo);
    end
    drive(1, 1, 7, 7, 4, 0, 0);
    n_cmp++;
    if (bus.redo_count !== 5'd0 || bus.can_redo !== 1'b0 || bus.used_count !== 5'd3) begin
      n_err++; $display("FAIL strokes_truncate redo=%0d can_redo=%b used=%0d want 0 0 3", bus.redo_count, bus.can_redo, bus.used_count);
    end
    // save and undo in the same cycle: save wins, undo dropped
    drive(1, 1, 8, 8, 5, 1, 0);
    n_cmp++;
    if (bus.used_count !== 5'd4 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.can_undo !== 1'b1) begin
      n_err++; $display("FAIL strokes_priority used=%0d busy=%b valid=%b can_undo=%b want 4 0 0 1",
                        bus.used_count, bus.busy, bus.out_valid, bus.can_undo);
    end
    push(8, 8, 5, 1);
    beats = 0;
    drive(0, 0, 0, 0, 0, 1, 0);
    wait_idle(20, ok);
    n_cmp++;
    if (!ok || sb.size() != 0 || beats != 1 || bus.used_count !== 5'd3) begin
      n_err++; $display("FAIL strokes_undo2 idle=%b beats=%0d used=%0d want 1 1 3", ok, beats, bus.used_count);
    end
  endtask

  task automatic test_wrap();
    logic ok;
    apply_reset();
    for (int i = 0; i < 20; i++) drive(1, (i == 0), 8'(i), 8'(i + 100), 3'(i), 0, 0);
    n_cmp++;
    if (bus.used_count !== 5'd16 || bus.redo_count !== 5'd0) begin
      n_err++; $display("FAIL wrap_full used=%0d redo=%0d want 16 0", bus.used_count, bus.redo_count);
    end
    for (int i = 19; i >= 4; i--) push(8'(i), 8'(i + 100), 3'(i), 1'b1);
    beats = 0;
    drive(0, 0, 0, 0, 0, 1, 0);
    wait_idle(60, ok);
    n_cmp++;
    if (!ok || sb.size() != 0 || beats != 16 || bus.used_count !== 5'd0 || bus.redo_count !== 5'd16) begin
      n_err++; $display("FAIL wrap_undo idle=%b left=%0d beats=%0d used=%0d redo=%0d want 1 0 16 0 16",
                        ok, sb.size(), beats, bus.used_count, bus.redo_count);
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    apply_reset();
    for (int i = 0; i < 4; i++) drive(1, (i == 0), 8'(10 + i), 8'(20), 3'(6), 0, 0);
    push(13, 20, 6, 1); push(12, 20, 6, 1); push(11, 20, 6, 1); push(10, 20, 6, 1);
    drive(0, 0, 0, 0, 0, 1, 0);
    @(negedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.x_out !== 8'd12 || bus.out_erase !== 1'b1 ||
          bus.used_count !== 5'd3 || bus.redo_count !== 5'd1 || bus.busy !== 1'b1) begin
        n_err++; $display("FAIL bp_hold cyc %0d valid=%b x=%0d erase=%b used=%0d redo=%0d busy=%b want 1 12 1 3 1 1",
                          i, bus.out_valid, bus.x_out, bus.out_erase, bus.used_count, bus.redo_count, bus.busy);
      end
      @(posedge clk); #1;
      bus.save = (i == 0); bus.stroke_begin = (i == 0); bus.x_in = 8'd99; bus.y_in = 8'd99;
      bus.undo = (i == 1);
    end
    bus.save = 1'b0; bus.undo = 1'b0; bus.stroke_begin = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle(20, ok);
    n_cmp++;
    if (!ok || sb.size() != 0 || bus.used_count !== 5'd0 || bus.redo_count !== 5'd4) begin
      n_err++; $display("FAIL bp_drain idle=%b left=%0d used=%0d redo=%0d want 1 0 0 4", ok, sb.size(), bus.used_count, bus.redo_count);
    end
    // redo must restore the original stroke, untouched by the ignored save
    push(10, 20, 6, 0); push(11, 20, 6, 0); push(12, 20, 6, 0); push(13, 20, 6, 0);
    beats = 0;
    drive(0, 0, 0, 0, 0, 0, 1);
    wait_idle(20, ok);
    n_cmp++;
    if (!ok || sb.size() != 0 || beats != 4 || bus.used_count !== 5'd4) begin
      n_err++; $display("FAIL bp_redo idle=%b left=%0d beats=%0d used=%0d want 1 0 4 4", ok, sb.size(), beats, bus.used_count);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    push(13, 20, 6, 1); push(12, 20, 6, 1); push(11, 20, 6, 1); push(10, 20, 6, 1);
    drive(0, 0, 0, 0, 0, 1, 0);
    wait_idle(20, ok);
    n_cmp++;
    if (!ok || sb.size() != 0 || bus.redo_count !== 5'd4) begin
      n_err++; $display("FAIL rstmid_setup idle=%b left=%0d redo=%0d want 1 0 4", ok, sb.size(), bus.redo_count);
    end
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL rstmid_playing valid=%b busy=%b want 1 1", bus.out_valid, bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_async valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.used_count !== 5'd0 || bus.redo_count !== 5'd0 || bus.can_undo !== 1'b0 || bus.can_redo !== 1'b0) begin
      n_err++; $display("FAIL rstmid_cleared used=%0d redo=%0d can_undo=%b can_redo=%b want 0 0 0 0",
                        bus.used_count, bus.redo_count, bus.can_undo, bus.can_redo);
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_redo_empty valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; beats = 0;
    rst_n = 1'b0;
    bus.save = 1'b0; bus.stroke_begin = 1'b0; bus.x_in = '0; bus.y_in = '0; bus.color_in = '0;
    bus.undo = 1'b0; bus.redo = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_undo_basic();
    test_redo_basic();
    test_strokes();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
